// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory.
// Registered PREADY/PSLVERR/PRDATA, fixed wait states, saturating error counter.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [15:0]           err_cnt
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            cnt_q;
  logic                  ready_q;
  logic                  slverr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [15:0]           err_cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_write;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // With zero wait states the response is built from the live setup-phase bus,
  // otherwise from the copy latched at setup.
  always_comb begin
    rsp_addr  = (state_q == StIdle) ? PADDR : addr_q;
    rsp_write = (state_q == StIdle) ? PWRITE : write_q;
    rsp_err   = (rsp_addr[1:0] != 2'b00) ||
                (32'(rsp_addr[ADDR_WIDTH-1:2]) >= DEPTH);
    rsp_rdata = '0;
    if (!rsp_err && !rsp_write) begin
      rsp_rdata = mem_q[rsp_addr[IdxW+1:2]];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      slverr_q  <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            state_q <= StAccess;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt_q   <= 4'(WAIT_STATES);
            ready_q <= (WAIT_STATES == 0);
            if (WAIT_STATES == 0) begin
              slverr_q <= rsp_err;
              rdata_q  <= rsp_rdata;
            end
          end
        end
        StAccess: begin
          if (!(PSEL && PENABLE)) begin
            // Abort: drop the transfer without side effects.
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
          end else if (ready_q) begin
            if (write_q && !slverr_q) begin
              mem_q[addr_q[IdxW+1:2]] <= wdata_q;
            end
            if (slverr_q && (err_cnt_q != 16'hFFFF)) begin
              err_cnt_q <= err_cnt_q + 16'd1;
            end
            state_q  <= StIdle;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              ready_q  <= 1'b1;
              slverr_q <= rsp_err;
              rdata_q  <= rsp_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;
  assign PRDATA  = rdata_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 3 and 2 wait states) on a shared bus,
// directed scenarios followed by random transfers checked against an array model.
module tb_apb_slave_mem;

  logic        clk;
  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [15:0] errcnt [3];

  int          checks;
  int          failures;
  int          ws [3];
  logic [31:0] mem_m [3][64];
  int unsigned errc_m [3];

  apb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .err_cnt(errcnt[0])
  );
  apb_slave_mem #(.WAIT_STATES(3)) u_dut1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .err_cnt(errcnt[1])
  );
  apb_slave_mem #(.WAIT_STATES(2)) u_dut2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .err_cnt(errcnt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      errc_m[d] = 0;
      for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel    = '0;
      penable = 1'b0;
    end
  endtask

  task automatic check_errcnt();
    for (int d = 0; d < 3; d++) check("err_cnt", 32'(errcnt[d]), errc_m[d]);
  endtask

  // Full transfer on instance d; returns at the negedge where PREADY is high,
  // leaving PSEL/PENABLE asserted so the following edge completes it.
  task automatic xfer(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd);
    int          waits;
    int          idx;
    logic        e;
    logic [31:0] exp_rd;
    idx    = int'(a[9:2]);
    e      = (a[1:0] != 2'b00) || (idx >= 64);
    exp_rd = (!wr && !e) ? mem_m[d][idx] : 32'h0;
    @(negedge clk);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(negedge clk);
    penable = 1'b1;
    paddr   = 10'($urandom);
    pwdata  = $urandom;
    pwrite  = 1'($urandom);
    waits   = 0;
    while (!pready[d] && waits < 40) begin
      @(negedge clk);
      waits++;
      paddr  = 10'($urandom);
      pwdata = $urandom;
      pwrite = 1'($urandom);
    end
    check("ready_latency", 32'(waits), 32'(ws[d]));
    check("pslverr", 32'(pslverr[d]), 32'(e));
    check("prdata", prdata[d], exp_rd);
    if (!e && wr) mem_m[d][idx] = wd;
    if (e && errc_m[d] < 65535) errc_m[d]++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ws[0] = 0; ws[1] = 3; ws[2] = 2;
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_clear();

    // Reset for two cycles
    preset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_pready", 32'(pready[d]), 32'h0);
      check("rst_pslverr", 32'(pslverr[d]), 32'h0);
      check("rst_prdata", prdata[d], 32'h0);
    end
    check_errcnt();
    preset = 1'b0;

    // Enable without select in IDLE is ignored
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_penable", 32'(pready), 32'h0);
    penable = 1'b0;

    // Reset then read, write then read
    xfer(0, 1'b0, 10'h000, 32'h0);
    xfer(0, 1'b1, 10'h010, 32'hDEADBEEF);
    xfer(0, 1'b0, 10'h010, 32'h0);
    check("raw_data", prdata[0], 32'hDEADBEEF);
    idle(1);
    check_errcnt();

    // Wait states, last valid index
    xfer(1, 1'b1, 10'h0FC, 32'hA5A5A5A5);
    xfer(1, 1'b0, 10'h0FC, 32'h0);
    check("ws_readback", prdata[1], 32'hA5A5A5A5);
    idle(1);

    // Error responses
    xfer(0, 1'b1, 10'h100, 32'h12345678);
    xfer(0, 1'b0, 10'h002, 32'h0);
    idle(1);
    check_errcnt();
    check("err_cnt_two", 32'(errcnt[0]), 32'd2);
    xfer(0, 1'b0, 10'h000, 32'h0);

    // Back-to-back writes then readback
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 10'(i * 4), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 10'(i * 4), 32'h0);
    idle(1);

    // Abort mid-ACCESS on the 2-wait-state instance
    xfer(2, 1'b1, 10'h000, 32'h11111111);
    @(negedge clk);
    psel = '0; psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 10'h000; pwdata = 32'hFFFFFFFF;
    @(negedge clk);
    penable = 1'b1;
    check("abort_wait0", 32'(pready[2]), 32'h0);
    @(negedge clk);
    check("abort_wait1", 32'(pready[2]), 32'h0);
    psel = '0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_pready", 32'(pready[2]), 32'h0);
    end
    xfer(2, 1'b0, 10'h000, 32'h0);
    check("abort_mem", prdata[2], 32'h11111111);
    idle(1);
    check_errcnt();

    // Reset during a wait cycle of a write
    @(negedge clk);
    psel = '0; psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 10'h0FC; pwdata = 32'h5A5A5A5A;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    check("midrst_pready", 32'(pready[1]), 32'h0);
    preset = 1'b0;
    psel = '0; penable = 1'b0;
    model_clear();
    check_errcnt();
    xfer(1, 1'b0, 10'h0FC, 32'h0);
    check("midrst_mem", prdata[1], 32'h0);
    idle(1);

    // Random transfers against the model
    for (int n = 0; n < 80; n++) begin
      int          d;
      logic [9:0]  a;
      d = int'($urandom_range(0, 2));
      a = 10'($urandom_range(0, 72) * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xfer(d, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
    check_errcnt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer: word-addressed register memory with configurable wait states and PSLVERR on bad addresses.
- It is the DUT behind the APB verification environment. The env driver generates SETUP/ACCESS phases into it, and the monitor, ref model and scoreboard check its PRDATA, PREADY and PSLVERR.
- It has one clock domain and no other interfaces besides a status counter.

Parameters:
- ADDR_WIDTH, 10: PADDR width in bits; byte address.
- DATA_WIDTH, 32: PWDATA/PRDATA width in bits. Fixed at 32 (4-byte words).
- DEPTH, 64: number of words implemented. Valid word index is 0..DEPTH-1.
- WAIT_STATES, 0: PREADY-low cycles inserted in every ACCESS phase. Legal range 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  ACCESS phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- err_cnt  out  16  saturating count of completed transfers that returned PSLVERR=1.

Behaviour:
- Reset (PRESET=1 at an edge):
  - state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0, err_cnt=0, wait counter=0.
  - All memory words are cleared to 0.
  - Reset overrides any in-flight transfer; no write commits on that edge.
- Address decode:
  - word index = PADDR[ADDR_WIDTH-1:2].
  - Error if PADDR[1:0]!=0, or if index >= DEPTH.
- FSM has two states, IDLE and ACCESS. PREADY, PSLVERR and PRDATA are all registered.
- IDLE:
  - Stays in IDLE; PREADY=0.
  - Setup detected (PSEL=1, PENABLE=0):
    - Latch PADDR, PWRITE and PWDATA; go to ACCESS.
    - Load counter=WAIT_STATES.
    - PREADY <= (WAIT_STATES==0).
    - If WAIT_STATES==0, also load the PSLVERR/PRDATA values given below on this same edge.
- ACCESS, PREADY=0:
  - Each edge: counter <= counter-1.
  - When counter==1, set PREADY<=1 and load PSLVERR/PRDATA on that edge.
  - Result: exactly WAIT_STATES PREADY-low cycles precede the ready cycle.
- Response values loaded with PREADY:
  - PSLVERR = decode error.
  - Read, no error: PRDATA = mem[index].
  - Read with error: PRDATA = 0.
  - Write: PRDATA = 0.
- Completion: edge with PSEL=1, PENABLE=1, PREADY=1.
  - Write without error: mem[index] <= latched PWDATA.
  - Errored write: memory unchanged.
  - If PSLVERR=1: err_cnt increments, saturating at 16'hFFFF.
  - Next: PREADY<=0, PSLVERR<=0, PRDATA<=0, state<=IDLE.
- Back-to-back: the cycle after completion may be a new setup; IDLE accepts it with no extra idle cycle required.
- Abort: in ACCESS, PSEL=0 or PENABLE=0 at any edge →
  - go to IDLE; PREADY/PSLVERR/PRDATA cleared.
  - No memory write, no err_cnt update.
  - A setup (PSEL=1, PENABLE=0) seen on that abort edge is not captured; the master must re-issue it.
- Stability: PADDR, PWRITE and PWDATA are sampled only at setup. Changes during ACCESS are ignored.
- Read-after-write: a read to the same address in the next transfer returns the new data.
- PSEL=0, PENABLE=1 in IDLE is ignored.

Test Plan:
- Reset then read: PRESET for 2 cycles, then read addr 0x000 with WAIT_STATES=0 → PREADY=1 in the first ACCESS cycle, PRDATA=0x00000000, PSLVERR=0, err_cnt=0.
- Write then read: write 0xDEADBEEF to 0x010, then read 0x010 → PRDATA=0xDEADBEEF, PSLVERR=0. Each transfer is 2 cycles.
- Wait states: WAIT_STATES=3, write 0xA5A5A5A5 to 0x0FC (index 63), then read it back → PREADY low for exactly 3 ACCESS cycles, high on the 4th; read returns 0xA5A5A5A5.
- Errors:
  - Write 0x12345678 to 0x100 (index 64) → PSLVERR=1 with PREADY.
  - Read 0x002 (misaligned) → PSLVERR=1, PRDATA=0.
  - err_cnt=2 afterwards; a read of 0x000 still returns its prior value.
- Back-to-back and abort:
  - 4 consecutive writes to 0x000/0x004/0x008/0x00C with no idle cycles → all complete; readback matches.
  - Then drop PSEL mid-ACCESS (WAIT_STATES=2) on a write of 0xFFFFFFFF to 0x000 → no memory change, PREADY stays 0.
- Reset mid-transfer: assert PRESET during an ACCESS wait cycle of a write → PREADY=0 the next cycle, target word reads 0, err_cnt=0.
